// File: rtl/gf2m_digit_mul_if.sv
// Request/response bundle for the digit-serial GF(2^m) multiplier.
// The requester drives start/op_mac/a/b/g and the multiplier answers with busy/done/result.
interface gf2m_digit_mul_if #(
  parameter int DATA_WIDTH = 163
);
  logic                  start;
  logic                  op_mac;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] g;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, op_mac, a, b, g,
    input  busy, done, result
  );

  modport slave (
    input  start, op_mac, a, b, g,
    output busy, done, result
  );
endinterface

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^m) multiply / multiply-accumulate modulo x^m + g(x).
// Each CAL cycle folds one D-bit digit of b (MSB digit first) into T with interleaved reduction.
module gf2m_digit_mul #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  gf2m_digit_mul_if.slave bus
);
  localparam int NDIGITS = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
  localparam int PW      = NDIGITS * DIGITAL;
  localparam int CW      = $clog2(NDIGITS) + 1;

  typedef enum logic {IDLE, CAL} state_t;

  state_t                state_q;
  logic                  busy_q, done_q, mac_q;
  logic [DATA_WIDTH-1:0] a_q, g_q, t_q, result_q;
  logic [PW-1:0]         b_q;
  logic [CW-1:0]         cnt_q;
  logic [DIGITAL-1:0]    digit;
  logic [DATA_WIDTH-1:0] t_d;
  int                    dig_idx;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_comb begin
    dig_idx = NDIGITS - 1 - int'(cnt_q);
    digit   = b_q[dig_idx*DIGITAL +: DIGITAL];
  end

  // Unrolled chain of D steps: multiply by x, reduce, then add a if the digit bit is set.
  always_comb begin
    t_d = t_q;
    for (int j = DIGITAL - 1; j >= 0; j--) begin
      t_d = {t_d[DATA_WIDTH-2:0], 1'b0} ^ (t_d[DATA_WIDTH-1] ? g_q : '0);
      if (digit[j]) t_d = t_d ^ a_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mac_q    <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      g_q      <= '0;
      t_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            g_q     <= bus.g;
            b_q     <= PW'(bus.b);
            mac_q   <= bus.op_mac;
            t_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CAL;
          end
        end
        CAL: begin
          t_q <= t_d;
          if (cnt_q < CW'(NDIGITS - 1)) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            // Accumulate reads the current result, so a back-to-back MAC sees the previous product.
            result_q <= mac_q ? (t_d ^ result_q) : t_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Directed plus randomized checks of gf2m_digit_mul at m=8/D=3 and m=163 with D in {1,7,64,163}.
// The reference multiplies fully and then reduces, independent of the digit-serial datapath.
module tb_gf2m_digit_mul;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  gf2m_digit_mul_if #(.DATA_WIDTH(8)) if8 ();
  gf2m_digit_mul #(.DATA_WIDTH(8), .DIGITAL(3)) u8 (.clk_i(clk), .rst_ni(rst_n), .bus(if8));

  logic           st, mac;
  logic [162:0]   av, bv, gv;
  logic [3:0]     busy_w, done_w;
  logic [162:0]   res_w [4];

  for (genvar k = 0; k < 4; k++) begin : g_d
    localparam int DS = (k == 0) ? 1 : (k == 1) ? 7 : (k == 2) ? 64 : 163;
    gf2m_digit_mul_if #(.DATA_WIDTH(163)) bus ();
    assign bus.start  = st;
    assign bus.op_mac = mac;
    assign bus.a      = av;
    assign bus.b      = bv;
    assign bus.g      = gv;
    assign busy_w[k]  = bus.busy;
    assign done_w[k]  = bus.done;
    assign res_w[k]   = bus.result;
    gf2m_digit_mul #(.DATA_WIDTH(163), .DIGITAL(DS)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  end

  logic [162:0] expv [4];
  int           lat163 [4];
  int           nd163 [4];

  function automatic logic [162:0] gmul(input logic [162:0] a, input logic [162:0] b,
                                        input logic [162:0] g, input int m);
    logic [325:0] p;
    p = '0;
    for (int i = 0; i < m; i++) if (b[i]) p = p ^ ({163'b0, a} << i);
    for (int i = 2*m - 2; i >= m; i--) begin
      if (p[i]) begin
        p[i] = 1'b0;
        p = p ^ ({163'b0, g} << (i - m));
      end
    end
    return p[162:0];
  endfunction

  function automatic int elat(input int k);
    int d;
    d = (k == 0) ? 1 : (k == 1) ? 7 : (k == 2) ? 64 : 163;
    return (163 + d - 1) / d + 1;
  endfunction

  function automatic logic [162:0] rnd163();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0];
  endfunction

  task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                      input logic m, output int lat, output int nb);
    if8.a = a; if8.b = b; if8.g = g; if8.op_mac = m; if8.start = 1'b1;
    lat = -1;
    nb  = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) if8.start = 1'b0;
      if (if8.busy) nb++;
      if (if8.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run163(input logic [162:0] a, input logic [162:0] b, input logic [162:0] g,
                        input logic m, input bit inject);
    logic [162:0] p;
    av = a; bv = b; gv = g; mac = m; st = 1'b1;
    p = gmul(a, b, g, 163);
    for (int k = 0; k < 4; k++) begin
      expv[k]   = m ? (expv[k] ^ p) : p;
      lat163[k] = -1;
      nd163[k]  = 0;
    end
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (c == 1) begin
        if (inject) begin
          av = rnd163(); bv = ~b; mac = ~m;
        end else st = 1'b0;
      end
      if (c == 2) st = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (done_w[k]) begin
          nd163[k]++;
          if (lat163[k] < 0) lat163[k] = c;
        end
      end
    end
  endtask

  task automatic check163(input string tag);
    for (int k = 0; k < 4; k++) begin
      chki($sformatf("%s_lat%0d", tag, k), lat163[k], elat(k));
      chki($sformatf("%s_ndone%0d", tag, k), nd163[k], 1);
      chk($sformatf("%s_res%0d", tag, k), res_w[k], expv[k]);
    end
  endtask

  initial begin
    int lat, nb, nd8, ndg;
    logic [162:0] ra;

    rst_n = 1'b0;
    if8.start = 1'b0; if8.op_mac = 1'b0; if8.a = '0; if8.b = '0; if8.g = '0;
    st = 1'b0; mac = 1'b0; av = '0; bv = '0; gv = '0;
    for (int k = 0; k < 4; k++) expv[k] = '0;
    tick();
    tick();
    chk("rst_busy8", 163'(if8.busy), '0);
    chk("rst_done8", 163'(if8.done), '0);
    chk("rst_res8", 163'(if8.result), '0);
    chk("rst_busy163", 163'(busy_w), '0);
    chk("rst_done163", 163'(done_w), '0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_res163_%0d", k), res_w[k], '0);
    rst_n = 1'b1;
    tick();

    // m=8 AES field
    run8(8'h57, 8'h83, 8'h1B, 1'b0, lat, nb);
    chki("m8_lat", lat, 4);
    chki("m8_busy_cycles", nb, 3);
    chk("m8_res_c1", 163'(if8.result), 163'hC1);
    tick();
    chk("m8_done_pulse", 163'(if8.done), '0);
    chk("m8_res_held", 163'(if8.result), 163'hC1);

    run8(8'h57, 8'h13, 8'h1B, 1'b0, lat, nb);
    chki("m8_lat2", lat, 4);
    chk("m8_res_fe", 163'(if8.result), 163'hFE);
    run8(8'h57, 8'h83, 8'h1B, 1'b1, lat, nb);
    chki("m8_b2b_lat", lat, 4);
    chk("m8_mac_3f", 163'(if8.result), 163'h3F);

    // m=163 directed
    ra = '0;
    ra[162] = 1'b1;
    run163(ra, 163'd2, 163'hC9, 1'b0, 1'b0);
    check163("wrap");
    chk("wrap_c9_d64", res_w[2], 163'hC9);
    ra = rnd163();
    run163(ra, 163'd1, 163'hC9, 1'b0, 1'b0);
    check163("ident");
    chk("ident_d64", res_w[2], ra);
    run163(ra, 163'd0, 163'hC9, 1'b0, 1'b0);
    check163("zero");
    chk("zero_d64", res_w[2], '0);

    // start while busy must be ignored
    run163(rnd163(), rnd163(), 163'hC9, 1'b0, 1'b1);
    check163("busy_start");

    for (int r = 0; r < 6; r++) begin
      run163(rnd163(), rnd163(), (r < 3) ? 163'hC9 : rnd163(), (r % 2) == 1, 1'b0);
      check163($sformatf("rnd%0d", r));
    end

    // reset during the second CAL cycle aborts everything
    if8.a = 8'h57; if8.b = 8'h83; if8.g = 8'h1B; if8.op_mac = 1'b0; if8.start = 1'b1;
    av = rnd163(); bv = rnd163(); gv = 163'hC9; mac = 1'b0; st = 1'b1;
    tick();
    if8.start = 1'b0; st = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy8", 163'(if8.busy), '0);
    chk("abort_done8", 163'(if8.done), '0);
    chk("abort_res8", 163'(if8.result), '0);
    chk("abort_busy163", 163'(busy_w), '0);
    chk("abort_done163", 163'(done_w), '0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_res163_%0d", k), res_w[k], '0);
      expv[k] = '0;
    end
    rst_n = 1'b1;
    nd8 = 0;
    ndg = 0;
    for (int c = 0; c < 170; c++) begin
      tick();
      if (if8.done) nd8++;
      for (int k = 0; k < 4; k++) if (done_w[k]) ndg++;
    end
    chki("abort_no_done8", nd8, 0);
    chki("abort_no_done163", ndg, 0);

    run8(8'h57, 8'h13, 8'h1B, 1'b1, lat, nb);
    chki("post_rst_lat8", lat, 4);
    chk("post_rst_res8", 163'(if8.result), 163'hFE);
    run163(rnd163(), rnd163(), 163'hC9, 1'b1, 1'b0);
    check163("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gf2m_digit_mul.md
Name: gf2m_digit_mul

Overview:
- Parametrised, self-contained digit-serial GF(2^m) multiplier for the ECC datapath.
- Computes result = a·b mod f(x), or result = a·b + result (multiply-accumulate), where f(x) = x^m + g(x).
- Consumes DIGITAL bits of b per cycle, MSB-first, with reduction interleaved, so every intermediate value stays m bits wide.
- Provides a busy/done handshake and returns to IDLE after each operation, so back-to-back multiplies need no reset.

Parameters:
- DATA_WIDTH, 163, field degree m; width of a, b, g and result.
- DIGITAL, 64, digit size D (bits of b consumed per cycle); 1 <= D <= DATA_WIDTH.
- NDIGITS, derived = ceil(DATA_WIDTH/DIGITAL); number of compute cycles. Localparam, not overridable.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- op_mac  in  1  captured with start; 0 = multiply, 1 = multiply-accumulate into result.
- a  in  DATA_WIDTH  multiplicand; captured on accept.
- b  in  DATA_WIDTH  multiplier; captured on accept, zero-extended internally to NDIGITS*DIGITAL bits.
- g  in  DATA_WIDTH  low coefficients of f(x); x^m term implicit. Captured on accept.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result is valid from this cycle on.
- result  out  DATA_WIDTH  product register; held until the next done.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0, internal a/b/g/T registers=0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CAL. No terminal state; the block never locks up.
- IDLE:
  - start=1 at an edge: capture a, g, op_mac, and b zero-padded on the MSB side; T<=0, counter<=0, busy<=1, state<=CAL.
  - start=0: nothing changes.
  - done is forced to 0 except in the cycle it is pulsed.
- CAL, one digit per edge. Digit d = bits of the padded b for digit index NDIGITS-1-counter (MSB digit first).
  - Update: for j = D-1 down to 0: acc = (acc·x mod f) XOR (d[j] ? a : 0), starting from acc = T. Then T <= acc.
  - acc·x mod f = (acc<<1)[m-1:0] XOR (acc[m-1] ? g : 0).
  - The update is a single-cycle unrolled chain of D shift-reduce steps.
- Leaving CAL:
  - If counter < NDIGITS-1: counter <= counter+1.
  - Else: result <= op_mac ? (acc XOR result) : acc; done <= 1; busy <= 0; counter <= 0; state <= IDLE.
- Latency: start sampled at edge E0; done=1 and the new result visible after edge E(NDIGITS), i.e. NDIGITS+1 cycles from the start cycle.
  - Throughput is one operation per NDIGITS+1 cycles.
- Back-to-back: start may be high in the same cycle done=1 (busy=0 there). It is accepted, and the MAC sees the just-written result.
- start while busy=1 is ignored; it is not queued.
- Inputs a/b/g/op_mac may change freely after the accept edge.
- Padding: pad bits of b are zero, so leading zero digits leave T=0. Bits of b above m-1 do not exist (port is m wide).
- Non-irreducible g is not checked; arithmetic is still mod x^m+g.
- Counter width = clog2(NDIGITS)+1; no wrap is possible.
- All arithmetic is XOR; no carries.

Test Plan:
- DATA_WIDTH=8, DIGITAL=3, g=8'h1B, a=8'h57, b=8'h83, op_mac=0 -> done exactly 4 cycles after the start cycle, result=8'hC1. busy high for 3 cycles.
- Same config, a=8'h57, b=8'h13 -> result=8'hFE. Then immediately a=8'h57, b=8'h83, op_mac=1 with start high in the done cycle -> accepted without a gap, result=8'hFE^8'hC1=8'h3F.
- Defaults (163/64), g=163'hC9, a=1<<162, b=2 -> result=163'hC9, done after 4 cycles. Then a=random, b=1 -> result=a. Then b=0 -> result=0.
- start pulsed while busy with different operands -> ignored. The first result is unchanged and exactly one done is produced.
- rst=0 in the 2nd CAL cycle -> next edge: busy=0, done=0, result=0. No done follows. A new start after rst=1 completes normally.
- Randomised over DIGITAL in {1, 7, 64, 163} at m=163 against a bit-serial software model -> all results match; latency = ceil(163/D)+1 cycles.
